// File: rtl/pixel_state.sv
// pixel_state: pixel frame sequencer FSM (FRAME_RESET -> EXPOSE -> CONVERT -> READ), optional watchdog via PIXEL_STATE_WATCHDOG_EN.
//   Ports: clk, state_reset (sync, active-high), read_reg[3:0] (read length), expose_finished, ADC_finished,
//   read, expose_enable, convert, frame_reset, ADC_reset (decoded from the state register only).
module pixel_state #(
  parameter int FRAME_RESET_CYCLES = 4,
  parameter int TIMEOUT_CYCLES     = 200
) (
  input  logic       clk,
  input  logic       state_reset,
  input  logic [3:0] read_reg,
  input  logic       expose_finished,
  input  logic       ADC_finished,
  output logic       read,
  output logic       expose_enable,
  output logic       convert,
  output logic       frame_reset,
  output logic       ADC_reset
);
  if (FRAME_RESET_CYCLES < 1 || FRAME_RESET_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("pixel_state: parameter out of range");
  end
`ifdef PIXEL_STATE_WATCHDOG_EN
  localparam int CW = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int CW = 8;
`endif
  localparam logic [CW-1:0] FR_LAST = CW'(FRAME_RESET_CYCLES - 1);
  typedef enum logic [1:0] {ST_FRAME_RESET, ST_EXPOSE, ST_CONVERT, ST_READ} state_t;
  state_t state;
  // shared per-state counter, cleared on every transition
  logic [CW-1:0] cnt;
  // last READ cycle index, latched on entry (read_reg of 0 behaves as 1)
  logic [3:0] rd_last;
  always_ff @(posedge clk) begin
    if (state_reset) begin
      state   <= ST_FRAME_RESET;
      cnt     <= '0;
      rd_last <= '0;
    end else begin
      case (state)
        ST_FRAME_RESET:
          if (cnt == FR_LAST) begin
            state <= ST_EXPOSE;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        ST_EXPOSE:
          if (expose_finished) begin
            state <= ST_CONVERT;
            cnt   <= '0;
          end
`ifdef PIXEL_STATE_WATCHDOG_EN
          else if (cnt == TO_LAST) begin
            state <= ST_FRAME_RESET;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
`endif
        ST_CONVERT:
          if (ADC_finished) begin
            state   <= ST_READ;
            cnt     <= '0;
            rd_last <= (read_reg == 4'd0) ? 4'd0 : read_reg - 4'd1;
          end
`ifdef PIXEL_STATE_WATCHDOG_EN
          else if (cnt == TO_LAST) begin
            state <= ST_FRAME_RESET;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
`endif
        default:
          if (cnt == CW'(rd_last)) begin
            state <= ST_FRAME_RESET;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
      endcase
    end
  end
  assign frame_reset   = state == ST_FRAME_RESET;
  assign ADC_reset     = state == ST_FRAME_RESET;
  assign expose_enable = state == ST_EXPOSE;
  assign convert       = state == ST_CONVERT;
  assign read          = state == ST_READ;
endmodule

// File: tb/tb_pixel_state.sv
// tb_pixel_state: directed self-checking bench for pixel_state (FRAME_RESET_CYCLES=4, TIMEOUT_CYCLES=10).
module tb_pixel_state;
  logic clk = 1'b0;
  logic state_reset = 1'b1;
  logic [3:0] read_reg = 4'd0;
  logic expose_finished = 1'b0;
  logic ADC_finished = 1'b0;
  logic read, expose_enable, convert, frame_reset, ADC_reset;
  logic [4:0] outs;
  int checks = 0;
  int errors = 0;
  localparam logic [4:0] O_FR = 5'b11000;
  localparam logic [4:0] O_EX = 5'b00100;
  localparam logic [4:0] O_CV = 5'b00010;
  localparam logic [4:0] O_RD = 5'b00001;
  assign outs = {frame_reset, ADC_reset, expose_enable, convert, read};
  pixel_state #(.FRAME_RESET_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk),
    .state_reset(state_reset),
    .read_reg(read_reg),
    .expose_finished(expose_finished),
    .ADC_finished(ADC_finished),
    .read(read),
    .expose_enable(expose_enable),
    .convert(convert),
    .frame_reset(frame_reset),
    .ADC_reset(ADC_reset)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    state_reset = 1'b1;
    tick();
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL reset_assert got %b want %b", outs, O_FR); end
    state_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== O_FR) begin errors++; $display("FAIL reset_fr%0d got %b want %b", i, outs, O_FR); end
    end
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL reset_expose got %b want %b", outs, O_EX); end
  endtask
  task automatic test_full_frame;
    ADC_finished = 1'b1;
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL ff_ex0 got %b want %b", outs, O_EX); end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== O_EX) begin errors++; $display("FAIL ff_ex%0d got %b want %b", i, outs, O_EX); end
    end
    expose_finished = 1'b1;
    ADC_finished = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== O_CV) begin errors++; $display("FAIL ff_cv%0d got %b want %b", i, outs, O_CV); end
    end
    ADC_finished = 1'b1;
    expose_finished = 1'b0;
    read_reg = 4'b0001;
    tick();
    checks++;
    if (outs !== O_RD) begin errors++; $display("FAIL ff_rd got %b want %b", outs, O_RD); end
    ADC_finished = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs !== O_FR) begin errors++; $display("FAIL ff_fr%0d got %b want %b", i, outs, O_FR); end
    end
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL ff_next_ex got %b want %b", outs, O_EX); end
  endtask
  task automatic test_free_run;
    expose_finished = 1'b1;
    ADC_finished = 1'b1;
    read_reg = 4'd1;
    for (int p = 0; p < 3; p++) begin
      tick();
      checks++;
      if (outs !== O_CV) begin errors++; $display("FAIL fr_cv p%0d got %b want %b", p, outs, O_CV); end
      tick();
      checks++;
      if (outs !== O_RD) begin errors++; $display("FAIL fr_rd p%0d got %b want %b", p, outs, O_RD); end
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (outs !== O_FR) begin errors++; $display("FAIL fr_fr p%0d c%0d got %b want %b", p, i, outs, O_FR); end
      end
      tick();
      checks++;
      if (outs !== O_EX) begin errors++; $display("FAIL fr_ex p%0d got %b want %b", p, outs, O_EX); end
    end
  endtask
  task automatic test_read_length;
    read_reg = 4'b1010;
    tick();
    checks++;
    if (outs !== O_CV) begin errors++; $display("FAIL rl_cv got %b want %b", outs, O_CV); end
    tick();
    checks++;
    if (outs !== O_RD) begin errors++; $display("FAIL rl_rd0 got %b want %b", outs, O_RD); end
    read_reg = 4'd0;
    for (int i = 1; i < 10; i++) begin
      tick();
      checks++;
      if (outs !== O_RD) begin errors++; $display("FAIL rl_rd%0d got %b want %b", i, outs, O_RD); end
    end
    tick();
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL rl_end10 got %b want %b", outs, O_FR); end
    for (int i = 0; i < 3; i++) tick();
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL rl_ex got %b want %b", outs, O_EX); end
    tick();
    tick();
    checks++;
    if (outs !== O_RD) begin errors++; $display("FAIL rl_zero_rd got %b want %b", outs, O_RD); end
    tick();
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL rl_zero_end got %b want %b", outs, O_FR); end
  endtask
  task automatic test_mid_reset;
    read_reg = 4'd5;
    for (int i = 0; i < 3; i++) tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (outs !== O_RD) begin errors++; $display("FAIL mr_in_read got %b want %b", outs, O_RD); end
    state_reset = 1'b1;
    tick();
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL mr_read_reset got %b want %b", outs, O_FR); end
    state_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== O_FR) begin errors++; $display("FAIL mr_fr%0d got %b want %b", i, outs, O_FR); end
    end
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL mr_ex got %b want %b", outs, O_EX); end
    expose_finished = 1'b0;
    ADC_finished = 1'b0;
    tick();
    state_reset = 1'b1;
    tick();
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL mr_expose_reset got %b want %b", outs, O_FR); end
    state_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== O_FR) begin errors++; $display("FAIL mr2_fr%0d got %b want %b", i, outs, O_FR); end
    end
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL mr2_ex got %b want %b", outs, O_EX); end
  endtask
  task automatic test_watchdog;
    expose_finished = 1'b0;
    ADC_finished = 1'bx;
    for (int i = 1; i < 10; i++) begin
      tick();
      checks++;
      if (outs !== O_EX) begin errors++; $display("FAIL wd_ex%0d got %b want %b", i, outs, O_EX); end
    end
    tick();
`ifdef PIXEL_STATE_WATCHDOG_EN
    checks++;
    if (outs !== O_FR) begin errors++; $display("FAIL wd_timeout got %b want %b", outs, O_FR); end
    ADC_finished = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL wd_reenter got %b want %b", outs, O_EX); end
`else
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL wd_none10 got %b want %b", outs, O_EX); end
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (outs !== O_EX) begin errors++; $display("FAIL wd_none40 got %b want %b", outs, O_EX); end
    ADC_finished = 1'b0;
`endif
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_free_run();
    test_read_length();
    test_mid_reset();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_state.md
PIXEL_STATE -- requirements
Module: pixel_state

Interface
REQ-001 Parameter FRAME_RESET_CYCLES, default 4: number of cycles spent in FRAME_RESET per frame (legal 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 200: watchdog limit for EXPOSE and CONVERT, used only when the watchdog is compiled in (legal 1..65535).
REQ-003 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 state_reset  input  1  reset, synchronous, active-high.
REQ-005 read_reg  input  4  number of read cycles per frame, sampled on entry to READ.
REQ-006 expose_finished  input  1  level; exposure complete, sampled only in EXPOSE.
REQ-007 ADC_finished  input  1  level; conversion complete, sampled only in CONVERT.
REQ-008 read  output  1  high in READ.
REQ-009 expose_enable  output  1  high in EXPOSE.
REQ-010 convert  output  1  high in CONVERT.
REQ-011 frame_reset  output  1  high in FRAME_RESET.
REQ-012 ADC_reset  output  1  high in FRAME_RESET.

Function
REQ-013 The block SHALL be a Moore FSM with states FRAME_RESET, EXPOSE, CONVERT, READ.
- One-hot outputs decoded only from the state register.
- No input SHALL reach an output combinationally.
REQ-014 FRAME_RESET SHALL last exactly FRAME_RESET_CYCLES cycles, then go to EXPOSE.
REQ-015 EXPOSE SHALL persist until expose_finished is 1 at a rising edge, then go to CONVERT on that edge.
- Minimum EXPOSE duration is one cycle.
REQ-016 CONVERT SHALL persist until ADC_finished is 1 at a rising edge, then go to READ on that edge.
- Minimum CONVERT duration is one cycle.
REQ-017 On the edge entering READ, read_reg SHALL be latched as N.
- READ SHALL last N cycles (N=0 treated as 1), then go to FRAME_RESET.
- read_reg changes during READ SHALL be ignored.
REQ-018 Inputs SHALL be ignored outside their own state.
- Unknown or stale values on expose_finished or ADC_finished outside EXPOSE or CONVERT SHALL NOT affect state.
REQ-019 With expose_finished and ADC_finished held at 1, the FSM SHALL cycle continuously.
- Period is FRAME_RESET_CYCLES + 1 + 1 + max(N,1) cycles.
REQ-020 Exactly one of read, expose_enable, convert SHALL be high outside FRAME_RESET; none of them is high in FRAME_RESET.
REQ-021 Internal counters SHALL be sized for the parameter maxima and SHALL NOT wrap within a state.

Reset
REQ-022 While state_reset is 1 at a rising edge, the FSM SHALL enter FRAME_RESET and clear all counters.
- This overrides every other transition, including reset mid-READ or mid-EXPOSE.
REQ-023 Output values in and after reset: frame_reset=1, ADC_reset=1, read=0, expose_enable=0, convert=0.
REQ-024 After state_reset deasserts, FRAME_RESET SHALL last FRAME_RESET_CYCLES full cycles before EXPOSE.

Configuration
REQ-025 Macro PIXEL_STATE_WATCHDOG_EN:
- When defined, if EXPOSE or CONVERT has lasted TIMEOUT_CYCLES cycles without its finish input, the FSM SHALL go to FRAME_RESET on the next edge, skipping READ.
- The watchdog count restarts on each entry to EXPOSE or CONVERT.
- When undefined, EXPOSE and CONVERT SHALL wait indefinitely and no watchdog logic SHALL exist.

Verification
REQ-026 Reset: state_reset=1 for 1 cycle -> frame_reset=1, ADC_reset=1, others 0; EXPOSE begins exactly 4 cycles after release.
REQ-027 Full frame: expose_finished rises 3 cycles into EXPOSE, ADC_finished 2 cycles into CONVERT, read_reg=4'b0001.
- Required: expose_enable high 3 cycles, convert high 2 cycles, read high 1 cycle, then frame_reset high 4 cycles.
REQ-028 Free-run: both finish inputs held 1, read_reg=1 -> 7-cycle period repeating.
- Each period is frame_reset 4 cycles, expose_enable 1, convert 1, read 1.
REQ-029 Read length: read_reg=4'b1010, then changed to 0 mid-READ -> read high exactly 10 cycles.
- Also read_reg=0 -> read high 1 cycle.
REQ-030 Mid-operation reset: state_reset=1 during READ -> next cycle frame_reset=1, read=0, with a full 4-cycle FRAME_RESET after release.
REQ-031 Watchdog, with PIXEL_STATE_WATCHDOG_EN and TIMEOUT_CYCLES=10: expose_finished held 0 -> expose_enable drops after 10 cycles and frame_reset rises.
- Without the macro, expose_enable stays high indefinitely.
